// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter for fetch (m0) and
// load/store (m1) onto a single-outstanding DV-pulse memory bus.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_data,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write,
  output logic [31:0] o_m0_data,
  output logic        o_m0_done,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_data,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write,
  output logic [31:0] o_m1_data,
  output logic        o_m1_done,
  output logic        o_m1_err,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  output logic        o_bus_DV,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST =
    TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] timer_q, timer_d;

  logic [31:0] addr_d, wdata_d;
  logic [2:0]  bhw_d;
  logic        wr_d;
  logic        dv_d;

  logic        done0_d, done1_d;
  logic        err0_d, err1_d;
  logic [31:0] rdata_d;

  logic        both;
  logic        pick;
  logic [2:0]  pick_bhw;
  logic        legal;
  logic [31:0] fit;

  assign o_busy = (state_q != IDLE);

  // pick a requester: lone request wins, ties go to the other one
  always_comb begin
    both     = i_m0_req & i_m1_req;
    pick     = both ? ~last_q : i_m1_req;
    pick_bhw = pick ? i_m1_bhw : i_m0_bhw;
    legal    = (pick_bhw == 3'b100) ||
               (pick_bhw == 3'b010) ||
               (pick_bhw == 3'b001);
  end

  // trim returned data to the latched access width
  always_comb begin
    fit = i_bus_data;
    unique case (1'b1)
      o_bhw[0]: fit = {24'h0, i_bus_data[7:0]};
      o_bhw[1]: fit = {16'h0, i_bus_data[15:0]};
      default:  fit = i_bus_data;
    endcase
  end

  // next state, bus latch and completion pulses
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    timer_d = timer_q;
    addr_d  = o_bus_address;
    wdata_d = o_bus_data;
    bhw_d   = o_bhw;
    wr_d    = o_write_notread;
    dv_d    = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdata_d = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (i_m0_req | i_m1_req) begin
          last_d = pick;
          if (!legal) begin
            err0_d = ~pick;
            err1_d = pick;
          end else begin
            gnt_d   = pick;
            addr_d  = pick ? i_m1_address : i_m0_address;
            wdata_d = pick ? i_m1_data : i_m0_data;
            bhw_d   = pick_bhw;
            wr_d    = pick ? i_m1_write : i_m0_write;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        dv_d    = 1'b1;
        timer_d = 32'h0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_bus_DV) begin
          rdata_d = fit;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = IDLE;
        end else if (TMO_EN && timer_q == TMO_LAST) begin
          err0_d  = ~gnt_q;
          err1_d  = gnt_q;
          state_d = DRAIN;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 32'd1;
        end
      end
      DRAIN: begin
        if (i_bus_DV) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state: fsm, round-robin pointer, grant, timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      timer_q <= 32'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
    end
  end

  // bus-side registers, held from grant to next grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_address   <= 32'h0;
      o_bus_data      <= 32'h0;
      o_bhw           <= 3'b000;
      o_write_notread <= 1'b0;
      o_bus_DV        <= 1'b0;
    end else begin
      o_bus_address   <= addr_d;
      o_bus_data      <= wdata_d;
      o_bhw           <= bhw_d;
      o_write_notread <= wr_d;
      o_bus_DV        <= dv_d;
    end
  end

  // master-side pulses; data is zero except with done
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_m0_done <= 1'b0;
      o_m1_done <= 1'b0;
      o_m0_err  <= 1'b0;
      o_m1_err  <= 1'b0;
      o_m0_data <= 32'h0;
      o_m1_data <= 32'h0;
    end else begin
      o_m0_done <= done0_d;
      o_m1_done <= done1_d;
      o_m0_err  <= err0_d;
      o_m1_err  <= err1_d;
      o_m0_data <= done0_d ? rdata_d : 32'h0;
      o_m1_data <= done1_d ? rdata_d : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner
// sequences and randomized rounds against a reference model.
module tb_mem_bus_arbiter;

  localparam int TMO = 16;
  localparam int NV  = 11;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  b;
    logic        w;
  } bus_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  bhw;
    logic        wr;
    logic [31:0] mem;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [2:0]  bhw [2];
  logic        wr [2];
  logic [31:0] m0_data, m1_data;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] bus_addr, bus_wd;
  logic [2:0]  bus_bhw;
  logic        bus_wr, bus_dv_o;
  logic [31:0] bus_rd;
  logic        bus_dv;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit          mem_silent = 0;
  bit          mem_fix_en = 0;
  logic [31:0] mem_fix = 0;
  int          mem_lat = 3;
  int          kick_req = 0;
  int          ibus_cyc = 0;
  int          overlap = 0;
  int          stab_bad = 0;
  logic        lg = 1'b1;

  bus_t bus_log [$];
  int   pulse_log [$];

  logic [2:0] ill_tab [5] =
    '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_m0_req       (req[0]),
    .i_m0_address   (addr[0]),
    .i_m0_data      (wdat[0]),
    .i_m0_bhw       (bhw[0]),
    .i_m0_write     (wr[0]),
    .o_m0_data      (m0_data),
    .o_m0_done      (m0_done),
    .o_m0_err       (m0_err),
    .i_m1_req       (req[1]),
    .i_m1_address   (addr[1]),
    .i_m1_data      (wdat[1]),
    .i_m1_bhw       (bhw[1]),
    .i_m1_write     (wr[1]),
    .o_m1_data      (m1_data),
    .o_m1_done      (m1_done),
    .o_m1_err       (m1_err),
    .o_bus_address  (bus_addr),
    .o_bus_data     (bus_wd),
    .o_bhw          (bus_bhw),
    .o_write_notread(bus_wr),
    .o_bus_DV       (bus_dv_o),
    .i_bus_data     (bus_rd),
    .i_bus_DV       (bus_dv),
    .o_busy         (busy)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic legal_ref(input logic [2:0] b);
    return (b == 3'b001) || (b == 3'b010) || (b == 3'b100);
  endfunction

  function automatic logic [31:0] fit_ref(
    input logic [31:0] x, input logic [2:0] b);
    if (b == 3'b001) return x % 256;
    if (b == 3'b010) return x % 65536;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_master(input int m,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [2:0] b,
                           input logic w,
                           output logic e,
                           output logic [31:0] rd);
    bit seen;
    seen = 0;
    e = 0;
    rd = 0;
    addr[m] = a;
    wdat[m] = d;
    bhw[m] = b;
    wr[m] = w;
    req[m] = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (m == 0 ? (m0_done | m0_err) : (m1_done | m1_err)) begin
        seen = 1;
        e = (m == 0) ? m0_err : m1_err;
        rd = (m == 0) ? m0_data : m1_data;
      end
    end
    req[m] = 1'b0;
    chk($sformatf("m%0d_complete", m), {31'b0, seen}, 32'd1);
    #1;
  endtask

  task automatic do_reset();
    req[0] = 0;
    req[1] = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : memory
    int cnt;
    int kick_seen;
    bit outst;
    logic [31:0] resp;
    bus_t cur;
    cnt = -1;
    kick_seen = 0;
    outst = 0;
    resp = 0;
    bus_dv = 0;
    bus_rd = 0;
    forever begin
      @(negedge clk);
      bus_dv = 0;
      if (rst) begin
        cnt = -1;
        outst = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus_dv = 1;
            bus_rd = resp;
            outst = 0;
            cnt = -1;
            ibus_cyc = cyc;
            cur = '{bus_addr, bus_wd, bus_bhw, bus_wr};
            if (bus_log.size() > 0 && cur != bus_log[$])
              stab_bad++;
          end
        end
        if (bus_dv_o) begin
          if (outst) overlap++;
          outst = 1;
          bus_log.push_back('{bus_addr, bus_wd, bus_bhw, bus_wr});
          resp = mem_fix_en ? mem_fix : mem_fn(bus_addr);
          if (!mem_silent) cnt = mem_lat;
        end
        if (kick_req != kick_seen) begin
          kick_seen = kick_req;
          bus_dv = 1;
          bus_rd = 32'hDEAD_BEEF;
          outst = 0;
          ibus_cyc = cyc;
        end
      end
    end
  end

  initial begin : pulse_mon
    forever begin
      @(posedge clk);
      #1;
      if (m0_done | m0_err) pulse_log.push_back(0);
      if (m1_done | m1_err) pulse_log.push_back(1);
    end
  end

  initial begin : main
    vec_t vecs [NV];
    logic e0, e1, ex;
    logic [31:0] d0, d1, dx;
    int c0, dvc, dnc, errc, nd;
    bus_t be;
    int mask, k, first, second;
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [2:0]  rb [2];
    logic        rwr [2];
    logic        rer [2];
    logic [31:0] rrd [2];
    int ord [$];
    bus_t expb [$];

    vecs[0]  = '{0, 32'h0000_0100, 32'h0, 3'b100, 1'b0,
                 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[1]  = '{1, 32'h0000_0203, 32'h0, 3'b001, 1'b0,
                 32'hAABB_CCDD, 1'b0, 32'h0000_00DD};
    vecs[2]  = '{1, 32'h0000_0202, 32'h0, 3'b010, 1'b0,
                 32'hAABB_CCDD, 1'b0, 32'h0000_CCDD};
    vecs[3]  = '{0, 32'h0000_0300, 32'hA5, 3'b001, 1'b1,
                 32'h0, 1'b0, 32'h0};
    vecs[4]  = '{1, 32'h0000_0400, 32'hBEEF, 3'b010, 1'b1,
                 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{1, 32'h0000_0500, 32'h55, 3'b000, 1'b1,
                 32'h1111_1111, 1'b1, 32'h0};
    vecs[6]  = '{0, 32'h0000_0600, 32'h0, 3'b011, 1'b0,
                 32'h2222_2222, 1'b1, 32'h0};
    vecs[7]  = '{0, 32'h0000_0700, 32'h0, 3'b111, 1'b0,
                 32'h3333_3333, 1'b1, 32'h0};
    vecs[8]  = '{1, 32'h0000_0800, 32'hCAFE_F00D, 3'b100, 1'b1,
                 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{0, 32'h0000_0904, 32'h0, 3'b100, 1'b0,
                 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[10] = '{0, 32'hFFFF_FF80, 32'h0, 3'b001, 1'b0,
                 32'h7766_5580, 1'b0, 32'h0000_0080};

    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 0;
      addr[m] = 0;
      wdat[m] = 0;
      bhw[m] = 0;
      wr[m] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero",
        {31'b0, |{m0_data, m1_data, m0_done, m1_done, m0_err,
                  m1_err, bus_addr, bus_wd, bus_bhw, bus_wr,
                  bus_dv_o, busy}}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mem_fix_en = 1;
    mem_lat = 3;
    for (int i = 0; i < NV; i++) begin
      mem_fix = vecs[i].mem;
      bus_log.delete();
      do_master(vecs[i].m, vecs[i].addr, vecs[i].wdata,
                vecs[i].bhw, vecs[i].wr, ex, dx);
      chk($sformatf("v%0d_err", i), {31'b0, ex},
          {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_data", i), dx, vecs[i].exp_data);
      chk($sformatf("v%0d_buscnt", i), bus_log.size(),
          vecs[i].exp_err ? 0 : 1);
      if (!vecs[i].exp_err) begin
        be = (bus_log.size() > 0) ? bus_log[0] : '0;
        chk($sformatf("v%0d_addr", i), be.a, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), be.d, vecs[i].wdata);
        chk($sformatf("v%0d_cfg", i), {28'b0, be.b, be.w},
            {28'b0, vecs[i].bhw, vecs[i].wr});
      end
      @(posedge clk);
      #1;
    end

    bus_log.delete();
    mem_fix = 32'h1234_5678;
    mem_lat = 5;
    c0 = cyc;
    dvc = -1;
    dnc = -1;
    d0 = 0;
    addr[0] = 32'h100;
    bhw[0] = 3'b100;
    wr[0] = 0;
    req[0] = 1;
    for (int i = 0; i < 30 && dnc < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus_dv_o && dvc < 0) dvc = cyc;
      if (m0_done) begin
        dnc = cyc;
        d0 = m0_data;
      end
    end
    req[0] = 0;
    chk("lat_req_to_busdv", dvc - c0, 32'd2);
    chk("lat_ibus_to_done", dnc - ibus_cyc, 32'd1);
    chk("lat_data", d0, 32'h1234_5678);
    chk("lat_one_busdv", bus_log.size(), 32'd1);
    chk("lat_ibus_after_dv", ibus_cyc - dvc, 32'd5);

    do_reset();
    mem_fix_en = 0;
    mem_lat = 2;
    bus_log.delete();
    pulse_log.delete();
    overlap = 0;
    for (int r = 0; r < 2; r++) begin
      fork
        do_master(0, 32'h1000 + r * 16, 0, 3'b100, 0, e0, d0);
        do_master(1, 32'h2000 + r * 16, 0, 3'b100, 0, e1, d1);
      join
      chk($sformatf("rr%0d_m0_data", r), d0,
          mem_fn(32'h1000 + r * 16));
      chk($sformatf("rr%0d_m1_data", r), d1,
          mem_fn(32'h2000 + r * 16));
    end
    chk("rr_pulse_cnt", pulse_log.size(), 32'd4);
    chk("rr_bus_cnt", bus_log.size(), 32'd4);
    for (int k2 = 0; k2 < 4; k2++) begin
      chk($sformatf("rr_order%0d", k2),
          (pulse_log.size() > k2) ? pulse_log[k2] : -1, k2 % 2);
      be = (bus_log.size() > k2) ? bus_log[k2] : '0;
      chk($sformatf("rr_addr%0d", k2), be.a,
          ((k2 % 2) ? 32'h2000 : 32'h1000) + (k2 / 2) * 16);
    end
    chk("rr_no_overlap", overlap, 32'd0);
    lg = 1'b1;

    bus_log.delete();
    pulse_log.delete();
    fork
      do_master(1, 32'h3000, 32'h55, 3'b000, 1, e1, d1);
      begin
        @(posedge clk);
        #1;
        do_master(0, 32'h3100, 0, 3'b100, 0, e0, d0);
      end
    join
    chk("ill_m1_err", {31'b0, e1}, 32'd1);
    chk("ill_m1_data", d1, 32'd0);
    chk("ill_m0_err", {31'b0, e0}, 32'd0);
    chk("ill_m0_data", d0, mem_fn(32'h3100));
    chk("ill_bus_cnt", bus_log.size(), 32'd1);
    be = (bus_log.size() > 0) ? bus_log[0] : '0;
    chk("ill_bus_addr", be.a, 32'h3100);
    chk("ill_order", (pulse_log.size() == 2) ?
        pulse_log[0] * 2 + pulse_log[1] : -1, 32'd2);

    do_reset();
    bus_log.delete();
    pulse_log.delete();
    mem_silent = 1;
    addr[0] = 32'h4000;
    bhw[0] = 3'b100;
    wr[0] = 0;
    req[0] = 1;
    dvc = -1;
    errc = -1;
    for (int i = 0; i < 60 && errc < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus_dv_o && dvc < 0) dvc = cyc;
      if (m0_err) begin
        errc = cyc;
        chk("tmo_data_zero", m0_data, 32'd0);
        chk("tmo_no_done", {31'b0, m0_done}, 32'd0);
        chk("tmo_busy", {31'b0, busy}, 32'd1);
      end
    end
    req[0] = 0;
    chk("tmo_err_cycle", errc - dvc, TMO);
    addr[1] = 32'h5000;
    bhw[1] = 3'b100;
    wr[1] = 0;
    req[1] = 1;
    nd = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus_dv_o) nd++;
    end
    chk("drain_no_busdv", nd, 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    mem_silent = 0;
    mem_lat = 2;
    kick_req++;
    dnc = -1;
    for (int i = 0; i < 30 && dnc < 0; i++) begin
      @(posedge clk);
      #1;
      if (m1_done) begin
        dnc = cyc;
        d1 = m1_data;
      end
    end
    req[1] = 0;
    #1;
    chk("drain_m1_served", {31'b0, dnc >= 0}, 32'd1);
    chk("drain_m1_data", d1, mem_fn(32'h5000));
    chk("drain_pulses", (pulse_log.size() == 2) ?
        pulse_log[0] * 2 + pulse_log[1] : -1, 32'd1);
    chk("drain_bus_cnt", bus_log.size(), 32'd2);
    lg = 1'b1;

    bus_log.delete();
    pulse_log.delete();
    mem_silent = 1;
    addr[0] = 32'h6000;
    bhw[0] = 3'b100;
    req[0] = 1;
    dvc = -1;
    for (int i = 0; i < 10 && dvc < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus_dv_o) dvc = cyc;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rstw_busy_before", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_outputs_zero",
        {31'b0, |{m0_data, m1_data, m0_done, m1_done, m0_err,
                  m1_err, bus_addr, bus_wd, bus_bhw, bus_wr,
                  bus_dv_o, busy}}, 32'd0);
    req[0] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1'b1;
    mem_silent = 0;
    kick_req++;
    repeat (4) @(posedge clk);
    #2;
    chk("rstw_no_pulse", pulse_log.size(), 32'd0);
    chk("rstw_idle", {31'b0, busy}, 32'd0);

    do_reset();
    @(posedge clk);
    #1;
    for (int r = 0; r < 60; r++) begin
      mask = $urandom_range(1, 3);
      mem_lat = $urandom_range(1, 6);
      for (int m = 0; m < 2; m++) begin
        ra[m] = $urandom();
        rw[m] = $urandom();
        rwr[m] = $urandom_range(0, 1);
        k = $urandom_range(0, 7);
        rb[m] = (k < 6) ? (3'b001 << (k % 3))
                        : ill_tab[$urandom_range(0, 4)];
        rer[m] = 0;
        rrd[m] = 0;
      end
      ord.delete();
      expb.delete();
      if (mask == 3) begin
        first = lg ? 0 : 1;
        second = 1 - first;
        ord.push_back(first);
        ord.push_back(second);
      end else begin
        ord.push_back(mask == 1 ? 0 : 1);
      end
      lg = ord[ord.size() - 1];
      foreach (ord[j])
        if (legal_ref(rb[ord[j]]))
          expb.push_back('{ra[ord[j]], rw[ord[j]],
                           rb[ord[j]], rwr[ord[j]]});
      bus_log.delete();
      pulse_log.delete();
      fork
        if ((mask & 1) != 0)
          do_master(0, ra[0], rw[0], rb[0], rwr[0], rer[0], rrd[0]);
        if ((mask & 2) != 0)
          do_master(1, ra[1], rw[1], rb[1], rwr[1], rer[1], rrd[1]);
      join
      foreach (ord[j]) begin
        k = ord[j];
        chk($sformatf("r%0d_m%0d_err", r, k), {31'b0, rer[k]},
            {31'b0, !legal_ref(rb[k])});
        chk($sformatf("r%0d_m%0d_data", r, k), rrd[k],
            legal_ref(rb[k]) ? fit_ref(mem_fn(ra[k]), rb[k]) : 0);
      end
      chk($sformatf("r%0d_npulse", r), pulse_log.size(),
          ord.size());
      foreach (ord[j])
        chk($sformatf("r%0d_order%0d", r, j),
            (pulse_log.size() > j) ? pulse_log[j] : -1, ord[j]);
      chk($sformatf("r%0d_nbus", r), bus_log.size(), expb.size());
      foreach (expb[j]) begin
        be = (bus_log.size() > j) ? bus_log[j] : '0;
        chk($sformatf("r%0d_bus%0d_addr", r, j), be.a, expb[j].a);
        chk($sformatf("r%0d_bus%0d_wd", r, j), be.d, expb[j].d);
        chk($sformatf("r%0d_bus%0d_cfg", r, j),
            {28'b0, be.b, be.w}, {28'b0, expb[j].b, expb[j].w});
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk("no_bus_overlap", overlap, 32'd0);
    chk("bus_fields_stable", stab_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
